// File: rtl/link_sync_ctrl.sv
// Link acquisition and supervision for the 8b/10b receive path: comma hunt,
// lock qualification, leaky-bucket error supervision and gating of decoded data.
module link_sync_ctrl #(
    parameter int LOCK_COMMAS  = 4,
    parameter int ERR_LIMIT    = 4,
    parameter int GOOD_RUN     = 16,
    parameter int HUNT_TIMEOUT = 1023
) (
    input  logic        byteclk,
    input  logic        rst,
    input  logic        force_resync,
    input  logic        sym_valid,
    input  logic [8:0]  sym_data,
    input  logic        sym_is_comma,
    input  logic        sym_err,
    output logic        hunt_req,
    output logic        realign,
    output logic        link_up,
    output logic        out_valid,
    output logic [8:0]  out_data,
    output logic [15:0] err_cnt,
    output logic [7:0]  relock_cnt
);
    // state  | meaning
    // HUNT   | decoder free-runs searching for a comma
    // VERIFY | collecting consecutive clean commas
    // LOCKED | forwarding data, supervising error rate
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0]  LOCK_N = 8'(LOCK_COMMAS);
    localparam logic [7:0]  ERR_N  = 8'(ERR_LIMIT);
    localparam logic [7:0]  GOOD_N = 8'(GOOD_RUN);
    localparam logic [15:0] TMO    = 16'(HUNT_TIMEOUT);

    state_t      state, state_nx;
    logic [7:0]  comma_cnt, comma_nx;
    logic [7:0]  bad_cnt, bad_nx;
    logic [7:0]  good_run, good_nx;
    logic [15:0] timer, timer_nx;
    logic        force_q;
    logic        realign_nx, out_valid_nx;
    logic [8:0]  out_data_nx;
    logic [15:0] err_nx;
    logic [7:0]  relock_nx;
    logic        clean_comma, err_sym;

    assign clean_comma = sym_valid & sym_is_comma & ~sym_err;
    assign err_sym     = sym_valid & sym_err;
    assign hunt_req    = (state == HUNT);
    assign link_up     = (state == LOCKED);

    always_comb begin
        state_nx     = state;
        comma_nx     = comma_cnt;
        bad_nx       = bad_cnt;
        good_nx      = good_run;
        timer_nx     = timer;
        realign_nx   = 1'b0;
        out_valid_nx = 1'b0;
        out_data_nx  = out_data;
        err_nx       = err_cnt;
        relock_nx    = relock_cnt;

        if (force_resync) begin
            // only the first cycle of a held request realigns the decoder
            state_nx   = HUNT;
            timer_nx   = '0;
            realign_nx = ~force_q;
        end else begin
            case (state)
                HUNT: begin
                    if (clean_comma) begin
                        state_nx = VERIFY;
                        comma_nx = 8'd1;
                        timer_nx = '0;
                    end else if (timer == TMO) begin
                        realign_nx = 1'b1;
                        timer_nx   = '0;
                    end else begin
                        timer_nx = timer + 16'd1;
                    end
                end
                VERIFY: begin
                    if (err_sym) begin
                        state_nx   = HUNT;
                        realign_nx = 1'b1;
                        timer_nx   = '0;
                    end else if (clean_comma) begin
                        timer_nx = '0;
                        if (comma_cnt + 8'd1 == LOCK_N) begin
                            state_nx  = LOCKED;
                            bad_nx    = '0;
                            good_nx   = '0;
                            relock_nx = (relock_cnt != 8'hFF) ? relock_cnt + 8'd1 : relock_cnt;
                        end else if (comma_cnt != 8'hFF) begin
                            comma_nx = comma_cnt + 8'd1;
                        end
                    end else if (timer == TMO) begin
                        state_nx   = HUNT;
                        realign_nx = 1'b1;
                        timer_nx   = '0;
                    end else begin
                        timer_nx = timer + 16'd1;
                    end
                end
                LOCKED: begin
                    if (err_sym) begin
                        err_nx  = (err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
                        good_nx = '0;
                        bad_nx  = (bad_cnt != 8'hFF) ? bad_cnt + 8'd1 : bad_cnt;
                        if (bad_cnt + 8'd1 == ERR_N) begin
                            state_nx   = HUNT;
                            realign_nx = 1'b1;
                            timer_nx   = '0;
                        end
                    end else if (sym_valid) begin
                        if (!sym_is_comma) begin
                            out_valid_nx = 1'b1;
                            out_data_nx  = sym_data;
                        end
                        // leaky bucket: each full good run forgives one error
                        if (good_run + 8'd1 == GOOD_N) begin
                            good_nx = '0;
                            if (bad_cnt != 8'd0)
                                bad_nx = bad_cnt - 8'd1;
                        end else if (good_run != 8'hFF) begin
                            good_nx = good_run + 8'd1;
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                    timer_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge byteclk) begin
        if (rst) begin
            state      <= HUNT;
            comma_cnt  <= '0;
            bad_cnt    <= '0;
            good_run   <= '0;
            timer      <= '0;
            force_q    <= 1'b0;
            realign    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err_cnt    <= '0;
            relock_cnt <= '0;
        end else begin
            state      <= state_nx;
            comma_cnt  <= comma_nx;
            bad_cnt    <= bad_nx;
            good_run   <= good_nx;
            timer      <= timer_nx;
            force_q    <= force_resync;
            realign    <= realign_nx;
            out_valid  <= out_valid_nx;
            out_data   <= out_data_nx;
            err_cnt    <= err_nx;
            relock_cnt <= relock_nx;
        end
    end
endmodule

// File: tb/tb_link_sync_ctrl.sv
// Bench for link_sync_ctrl: directed scenarios plus a randomized run checked
// against a behavioural model of the acquisition/supervision rules.
module tb_link_sync_ctrl;
    localparam int LC = 4, EL = 4, GR = 16, HT = 1023;
    localparam logic [8:0] K28_5 = 9'h1BC;
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic        byteclk = 1'b0;
    logic        rst, force_resync, sym_valid, sym_is_comma, sym_err;
    logic [8:0]  sym_data;
    logic        hunt_req, realign, link_up, out_valid;
    logic [8:0]  out_data;
    logic [15:0] err_cnt;
    logic [7:0]  relock_cnt;

    int errors = 0;
    int checks = 0;

    int         m_mode, m_commas, m_bad, m_good, m_quiet;
    bit         m_fprev;
    bit         e_realign, e_valid;
    logic [8:0] e_data;
    int         e_err, e_relock;

    always #5 byteclk = ~byteclk;

    link_sync_ctrl #(.LOCK_COMMAS(LC), .ERR_LIMIT(EL), .GOOD_RUN(GR), .HUNT_TIMEOUT(HT)) dut (
        .byteclk(byteclk), .rst(rst), .force_resync(force_resync),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_is_comma(sym_is_comma),
        .sym_err(sym_err), .hunt_req(hunt_req), .realign(realign), .link_up(link_up),
        .out_valid(out_valid), .out_data(out_data), .err_cnt(err_cnt), .relock_cnt(relock_cnt)
    );

    task automatic model_reset();
        m_mode = M_HUNT; m_commas = 0; m_bad = 0; m_good = 0; m_quiet = 0; m_fprev = 0;
        e_realign = 0; e_valid = 0; e_data = '0; e_err = 0; e_relock = 0;
    endtask

    task automatic go_hunt_realign();
        m_mode = M_HUNT; m_quiet = 0; e_realign = 1;
    endtask

    task automatic model_step(input logic fr, input logic sv, input logic [8:0] sd,
                              input logic cm, input logic er);
        bit clean_c, bad_sym;
        clean_c = sv && cm && !er;
        bad_sym = sv && er;
        e_realign = 0;
        e_valid = 0;
        if (fr) begin
            e_realign = !m_fprev;
            m_mode = M_HUNT;
            m_quiet = 0;
        end else if (m_mode == M_HUNT) begin
            if (clean_c) begin
                m_mode = M_VERIFY; m_commas = 1; m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet > HT) begin e_realign = 1; m_quiet = 0; end
            end
        end else if (m_mode == M_VERIFY) begin
            if (bad_sym) go_hunt_realign();
            else if (clean_c) begin
                m_commas++;
                m_quiet = 0;
                if (m_commas >= LC) begin
                    m_mode = M_LOCKED; m_bad = 0; m_good = 0;
                    if (e_relock < 255) e_relock++;
                end
            end else begin
                m_quiet++;
                if (m_quiet > HT) go_hunt_realign();
            end
        end else begin
            if (bad_sym) begin
                if (e_err < 65535) e_err++;
                m_good = 0;
                m_bad++;
                if (m_bad >= EL) go_hunt_realign();
            end else if (sv) begin
                if (!cm) begin e_valid = 1; e_data = sd; end
                m_good++;
                if (m_good == GR) begin
                    m_good = 0;
                    if (m_bad > 0) m_bad--;
                end
            end
        end
        m_fprev = fr;
    endtask

    task automatic tick(input logic r, input logic fr, input logic sv, input logic [8:0] sd,
                        input logic cm, input logic er);
        rst = r; force_resync = fr; sym_valid = sv; sym_data = sd; sym_is_comma = cm; sym_err = er;
        @(posedge byteclk);
        if (r) model_reset();
        else model_step(fr, sv, sd, cm, er);
        #1;
    endtask

    task automatic send_comma();
        tick(0, 0, 1, K28_5, 1, 0);
    endtask

    task automatic send_data(input logic [8:0] d);
        tick(0, 0, 1, d, 0, 0);
    endtask

    task automatic send_err();
        tick(0, 0, 1, 9'($urandom), 1'($urandom), 1);
    endtask

    task automatic idle();
        tick(0, 0, 0, 9'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        tick(1, 1'($urandom), 1, 9'($urandom), 1'($urandom), 1'($urandom));
        tick(1, 0, 0, 9'h000, 0, 0);
    endtask

    task automatic lock_link();
        do_reset();
        for (int i = 0; i < LC; i++) send_comma();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1, 1'($urandom), 1, 9'($urandom), 1'($urandom), 1'($urandom));
        checks++; if (hunt_req !== 1'b1) begin errors++; $display("FAIL reset_hunt_req got=%b exp=1", hunt_req); end
        checks++; if (realign !== 1'b0) begin errors++; $display("FAIL reset_realign got=%b exp=0", realign); end
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up got=%b exp=0", link_up); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock_cnt got=%0d exp=0", relock_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        send_comma();
        checks++;
        if (hunt_req !== 1'b0 || link_up !== 1'b0) begin
            errors++; $display("FAIL lock_verify_entry got hunt=%b link=%b exp hunt=0 link=0", hunt_req, link_up);
        end
        send_comma();
        send_comma();
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL lock_early got link=%b exp=0", link_up); end
        send_comma();
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL lock_link_up got=%b exp=1", link_up); end
        checks++; if (relock_cnt !== 8'd1) begin errors++; $display("FAIL lock_relock_cnt got=%0d exp=1", relock_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_comma_fwd got out_valid=%b exp=0", out_valid); end
        send_data(9'h0AB);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 9'h0AB) begin
            errors++; $display("FAIL lock_first_data got valid=%b data=%h exp valid=1 data=0ab", out_valid, out_data);
        end
    endtask

    task automatic test_err_drop();
        int pulses = 0;
        lock_link();
        for (int i = 0; i < EL; i++) begin
            send_err();
            if (realign) pulses++;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_err_forwarded i=%0d got=%b exp=0", i, out_valid); end
            if (i < EL - 1) begin
                checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL drop_early i=%0d got link=%b exp=1", i, link_up); end
                for (int j = 0; j < 3; j++) begin
                    send_data({1'b0, 8'($urandom)});
                    if (realign) pulses++;
                end
            end
        end
        checks++;
        if (link_up !== 1'b0 || hunt_req !== 1'b1) begin
            errors++; $display("FAIL drop_state got link=%b hunt=%b exp link=0 hunt=1", link_up, hunt_req);
        end
        checks++; if (err_cnt !== 16'd4) begin errors++; $display("FAIL drop_err_cnt got=%0d exp=4", err_cnt); end
        idle();
        if (realign) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL drop_realign_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_leaky();
        int pulses = 0;
        logic [8:0] d;
        lock_link();
        for (int it = 0; it < 10; it++) begin
            send_err();
            if (realign) pulses++;
            for (int j = 0; j < GR; j++) begin
                d = {1'b0, 8'($urandom)};
                send_data(d);
                if (realign) pulses++;
                checks++;
                if (out_valid !== 1'b1 || out_data !== d) begin
                    errors++; $display("FAIL leaky_fwd it=%0d j=%0d got valid=%b data=%h exp valid=1 data=%h", it, j, out_valid, out_data, d);
                end
            end
            checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL leaky_link it=%0d got=%b exp=1", it, link_up); end
        end
        checks++; if (err_cnt !== 16'd10) begin errors++; $display("FAIL leaky_err_cnt got=%0d exp=10", err_cnt); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL leaky_realign got=%0d exp=0", pulses); end
    endtask

    task automatic test_timeout();
        int n = 0, first = 0, second = 0, not_hunt = 0;
        do_reset();
        for (int c = 1; c <= 2100; c++) begin
            if ($urandom_range(3) == 0) tick(0, 0, 1, {1'b0, 8'($urandom)}, 0, 1'($urandom));
            else idle();
            if (realign) begin
                n++;
                if (n == 1) first = c;
                else if (n == 2) second = c;
            end
            if (hunt_req !== 1'b1) not_hunt++;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL timeout_count got=%0d exp=2", n); end
        checks++; if (first != 1024) begin errors++; $display("FAIL timeout_first got=%0d exp=1024", first); end
        checks++; if (second != 2048) begin errors++; $display("FAIL timeout_second got=%0d exp=2048", second); end
        checks++; if (not_hunt != 0) begin errors++; $display("FAIL timeout_hunt_req got=%0d cycles low exp=0", not_hunt); end
    endtask

    task automatic test_verify_abort();
        int early = 0;
        do_reset();
        send_comma();
        send_comma();
        checks++; if (hunt_req !== 1'b0) begin errors++; $display("FAIL vabort_in_verify got hunt=%b exp=0", hunt_req); end
        tick(0, 0, 1, K28_5, 1, 1);
        checks++;
        if (realign !== 1'b1 || hunt_req !== 1'b1) begin
            errors++; $display("FAIL vabort_err_comma got realign=%b hunt=%b exp 1 1", realign, hunt_req);
        end
        checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL vabort_relock got=%0d exp=0", relock_cnt); end
        send_comma();
        for (int c = 1; c <= HT; c++) begin
            if ($urandom_range(1) == 0) send_data({1'b0, 8'($urandom)});
            else tick(0, 0, 0, 9'($urandom), 0, 0);
            if (realign || hunt_req) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL vtimeout_early got=%0d cycles exp=0", early); end
        tick(0, 0, 0, 9'h000, 0, 0);
        checks++;
        if (realign !== 1'b1 || hunt_req !== 1'b1) begin
            errors++; $display("FAIL vtimeout_fire got realign=%b hunt=%b exp 1 1", realign, hunt_req);
        end
    endtask

    task automatic test_force();
        int n = 0, low = 0, first = 0;
        lock_link();
        tick(0, 1, 1, 9'h055, 0, 0);
        checks++;
        if (link_up !== 1'b0 || realign !== 1'b1 || hunt_req !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL force_enter got link=%b realign=%b hunt=%b valid=%b exp 0 1 1 0",
                               link_up, realign, hunt_req, out_valid);
        end
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(1) == 0) tick(0, 1, 1, K28_5, 1, 0);
            else tick(0, 1, 1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
            if (realign) n++;
            if (hunt_req !== 1'b1) low++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL force_hold_realign got=%0d exp=0", n); end
        checks++; if (low != 0) begin errors++; $display("FAIL force_hold_hunt got=%0d cycles low exp=0", low); end
        for (int c = 1; c <= 1100; c++) begin
            tick(0, 0, 0, 9'h000, 0, 0);
            if (realign && first == 0) first = c;
        end
        checks++; if (first != 1024) begin errors++; $display("FAIL force_release_timer got=%0d exp=1024", first); end
    endtask

    task automatic test_rst_mid();
        lock_link();
        send_err();
        send_data(9'h012);
        tick(1, 0, 1, 9'h0CD, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || link_up !== 1'b0 || hunt_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got valid=%b link=%b hunt=%b exp 0 0 1", out_valid, link_up, hunt_req);
        end
        checks++;
        if (err_cnt !== 16'd0 || relock_cnt !== 8'd0 || realign !== 1'b0) begin
            errors++; $display("FAIL rstmid_counters got err=%0d relock=%0d realign=%b exp 0 0 0", err_cnt, relock_cnt, realign);
        end
    endtask

    task automatic test_random();
        int err_pct, comma_pct;
        logic r, fr, sv, cm, er;
        bit e_hunt, e_link;
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            if (c % 500 == 0) begin
                err_pct   = (c / 500) % 3 == 0 ? 0 : ((c / 500) % 3 == 1 ? 2 : 10);
                comma_pct = 10 + 25 * ((c / 700) % 3);
            end
            r  = ($urandom_range(999) == 0);
            fr = ($urandom_range(199) == 0);
            sv = ($urandom_range(99) < 85);
            cm = ($urandom_range(99) < comma_pct);
            er = ($urandom_range(99) < err_pct);
            tick(r, fr, sv, cm ? K28_5 : 9'($urandom), cm, er);
            e_hunt = (m_mode == M_HUNT);
            e_link = (m_mode == M_LOCKED);
            checks++;
            if (hunt_req !== e_hunt || link_up !== e_link || realign !== e_realign ||
                out_valid !== e_valid || out_data !== e_data ||
                err_cnt !== 16'(e_err) || relock_cnt !== 8'(e_relock)) begin
                errors++;
                $display("FAIL random c=%0d got h=%b l=%b r=%b v=%b d=%h e=%0d rl=%0d exp h=%b l=%b r=%b v=%b d=%h e=%0d rl=%0d",
                         c, hunt_req, link_up, realign, out_valid, out_data, err_cnt, relock_cnt,
                         e_hunt, e_link, e_realign, e_valid, e_data, e_err, e_relock);
            end
        end
    endtask

    initial begin
        rst = 1'b1; force_resync = 1'b0; sym_valid = 1'b0; sym_data = '0; sym_is_comma = 1'b0; sym_err = 1'b0;
        model_reset();
        test_reset();
        test_lock();
        test_err_drop();
        test_leaky();
        test_timeout();
        test_verify_abort();
        test_force();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
